// File: rtl/timer_tick_gen_pkg.sv
// Shared types for the programmable tick generator.
package timer_tick_gen_pkg;

    localparam int STATE_W = 1;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE,
        S_RUN
    } t_timer_state;

endpackage

// File: rtl/timer_tick_gen_down_counter.sv
// Loadable down counter used as the period timer; load wins over decrement.
module down_counter_load #(
    parameter int N = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [N-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero,
    output logic [N-1:0] o_value
);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            o_value <= '0;
        else if (i_load)
            o_value <= i_load_val;
        else if (i_dec)
            o_value <= o_value - N'(1);
    end

    assign o_zero = (o_value == '0);

endmodule

// File: rtl/timer_tick_gen.sv
// Programmable period tick generator. Define TIMER_TICK_GEN_PERIODIC_EN for
// periodic reload; otherwise the timer is one-shot.
module timer_tick_gen
    import timer_tick_gen_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [N-1:0] i_k,
    input  logic         i_start,
    input  logic         i_stop,
    output logic         o_tick,
    output logic         o_busy,
    output logic [N-1:0] o_remaining,
    output logic [N-1:0] o_ticks
);

`ifdef TIMER_TICK_GEN_PERIODIC_EN
    localparam bit PERIODIC = 1'b1;
`else
    localparam bit PERIODIC = 1'b0;
`endif

    t_timer_state state;
    logic [N-1:0] period;
    logic         accept;
    logic         expire;
    logic         cnt_zero;
    logic         cnt_load;
    logic         cnt_dec;
    logic [N-1:0] cnt_load_val;

    assign accept = i_start && !i_stop && (i_k != '0);
    // Period end only counts when neither stop nor restart claims this edge.
    assign expire = (state == S_RUN) && cnt_zero && !i_stop && !accept;

    assign cnt_load = i_stop || accept || (expire && PERIODIC);
    assign cnt_dec  = (state == S_RUN) && !cnt_zero && !i_stop && !accept;

    always_comb begin
        cnt_load_val = '0;
        if (i_stop)
            cnt_load_val = '0;
        else if (accept)
            cnt_load_val = i_k - N'(1);
        else
            cnt_load_val = period - N'(1);
    end

    down_counter_load #(.N(N)) u_cnt (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (cnt_load),
        .i_load_val (cnt_load_val),
        .i_dec      (cnt_dec),
        .o_zero     (cnt_zero),
        .o_value    (o_remaining)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= S_IDLE;
            period  <= '0;
            o_tick  <= 1'b0;
            o_ticks <= '0;
        end else begin
            o_tick <= expire;
            if (i_stop) begin
                state <= S_IDLE;
            end else if (accept) begin
                state   <= S_RUN;
                period  <= i_k;
                o_ticks <= '0;
            end else if (expire) begin
                o_ticks <= o_ticks + N'(1);
                if (!PERIODIC)
                    state <= S_IDLE;
            end
        end
    end

    assign o_busy = (state == S_RUN);

endmodule

// File: tb/tb_timer_tick_gen.sv
// Self-checking bench for timer_tick_gen: vector table, directed corners, random vs. model.
module tb_timer_tick_gen;

    localparam int N = 8;
`ifdef TIMER_TICK_GEN_PERIODIC_EN
    localparam bit PER = 1'b1;
`else
    localparam bit PER = 1'b0;
`endif

    logic         i_clk;
    logic         i_reset;
    logic [N-1:0] i_k;
    logic         i_start;
    logic         i_stop;
    logic         o_tick;
    logic         o_busy;
    logic [N-1:0] o_remaining;
    logic [N-1:0] o_ticks;

    timer_tick_gen #(.N(N)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_k         (i_k),
        .i_start     (i_start),
        .i_stop      (i_stop),
        .o_tick      (o_tick),
        .o_busy      (o_busy),
        .o_remaining (o_remaining),
        .o_ticks     (o_ticks)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic         start;
        logic         stop;
        logic [N-1:0] k;
        logic         tick;
        logic         busy;
        logic [N-1:0] rem;
        logic [N-1:0] ticks;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // Reference model: elapsed edges since start, ticks at multiples of the period.
    bit m_run;
    int m_p;
    int m_n;
    int m_ticks;
    bit m_tick;

    function automatic vec_t vec(input bit s, input bit st, input int k,
                                 input bit tk, input bit b, input int r, input int t);
        vec_t v;
        v.start = s;  v.stop = st;  v.k = N'(k);
        v.tick = tk;  v.busy = b;   v.rem = N'(r);  v.ticks = N'(t);
        return v;
    endfunction

    task automatic check(input string name, input logic [2*N+1:0] got, input logic [2*N+1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got tick/busy/rem/ticks=%0b/%0b/%0d/%0d expected %0b/%0b/%0d/%0d",
                     name, got[2*N+1], got[2*N], got[2*N-1:N], got[N-1:0],
                     exp[2*N+1], exp[2*N], exp[2*N-1:N], exp[N-1:0]);
        end
    endtask

    function automatic logic [2*N+1:0] dut_out();
        return {o_tick, o_busy, o_remaining, o_ticks};
    endfunction

    function automatic logic [2*N+1:0] model_out();
        int r;
        r = m_run ? (m_p - 1 - (m_n % m_p)) : 0;
        return {m_tick, m_run, N'(r), N'(m_ticks)};
    endfunction

    task automatic model_reset();
        m_run = 0; m_p = 0; m_n = 0; m_ticks = 0; m_tick = 0;
    endtask

    task automatic model_edge(input bit s, input bit st, input int k);
        if (st) begin
            m_run = 0; m_tick = 0;
        end else if (s && k != 0) begin
            m_run = 1; m_p = k; m_n = 0; m_ticks = 0; m_tick = 0;
        end else if (m_run) begin
            m_n++;
            if (m_n % m_p == 0) begin
                m_tick = 1;
                m_ticks = (m_ticks + 1) % (1 << N);
                if (!PER) m_run = 0;
            end else begin
                m_tick = 0;
            end
        end else begin
            m_tick = 0;
        end
    endtask

    task automatic step(input string name, input bit s, input bit st, input int k);
        @(negedge i_clk);
        i_start = s; i_stop = st; i_k = N'(k);
        @(posedge i_clk);
        model_edge(s, st, k);
        #1;
        check(name, dut_out(), model_out());
    endtask

    vec_t tbl[16];

    initial begin
        i_reset = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_k = '0;
        model_reset();
        #12;
        check("reset", dut_out(), '0);
        @(negedge i_clk);
        i_reset = 1'b0;

        tbl[0]  = vec(1, 0, 3, 0, 1,      2,      0);
        tbl[1]  = vec(0, 0, 0, 0, 1,      1,      0);
        tbl[2]  = vec(0, 0, 0, 0, 1,      0,      0);
        tbl[3]  = vec(0, 1, 0, 0, 0,      0,      0);
        tbl[4]  = vec(1, 1, 3, 0, 0,      0,      0);
        tbl[5]  = vec(1, 0, 0, 0, 0,      0,      0);
        tbl[6]  = vec(1, 0, 2, 0, 1,      1,      0);
        tbl[7]  = vec(0, 0, 0, 0, 1,      0,      0);
        tbl[8]  = vec(0, 0, 0, 1, PER,    PER,    1);
        tbl[9]  = vec(0, 0, 0, 0, PER,    0,      1);
        tbl[10] = vec(1, 0, 6, 0, 1,      5,      0);
        tbl[11] = vec(0, 0, 0, 0, 1,      4,      0);
        tbl[12] = vec(0, 0, 0, 0, 1,      3,      0);
        tbl[13] = vec(1, 0, 2, 0, 1,      1,      0);
        tbl[14] = vec(0, 0, 0, 0, 1,      0,      0);
        tbl[15] = vec(0, 0, 0, 1, PER,    PER,    1);

        for (int i = 0; i < 16; i++) begin
            step($sformatf("model_row%0d", i), tbl[i].start, tbl[i].stop, int'(tbl[i].k));
            check($sformatf("table_row%0d", i), dut_out(),
                  {tbl[i].tick, tbl[i].busy, tbl[i].rem, tbl[i].ticks});
        end
        step("stop_after_table", 0, 1, 0);

        // k=4 held for 20 edges after start.
        step("k4_start", 1, 0, 4);
        for (int i = 0; i < 20; i++) step("k4_run", 0, 0, 4);
        check("k4_tick_count", dut_out() & {{(N+2){1'b0}}, {N{1'b1}}}, (2*N+2)'(PER ? 5 : 1));
        step("k4_stop", 0, 1, 0);

        // k=1 long enough for the tick counter to wrap.
        step("k1_start", 1, 0, 1);
        for (int i = 0; i < (1 << N) + 2; i++) step("k1_run", 0, 0, 0);
        check("k1_wrap_count", dut_out() & {{(N+2){1'b0}}, {N{1'b1}}}, (2*N+2)'(PER ? 2 : 1));

        // Asynchronous reset between edges while running.
        step("pre_areset_start", 1, 0, 9);
        step("pre_areset_run", 0, 0, 0);
        #2 i_reset = 1'b1;
        #1 check("async_reset", dut_out(), '0);
        model_reset();
        @(negedge i_clk);
        i_reset = 1'b0;
        step("post_reset_idle", 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            bit s, st;
            int k;
            s  = ($urandom_range(0, 7) == 0);
            st = ($urandom_range(0, 15) == 0);
            k  = $urandom_range(1, 7);
            step("random", s, st, k);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
